// File: rtl/pipe4_hazard_ctrl.sv
// Hazard/sequencing controller for a 4-stage IF/ID/EXE/WB regfile pipeline.
// Tracks in-flight destinations, registers EXE forward selects, holds for multi-cycle ops.
module pipe4_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wen,
  input  logic                  id_multi,
  output logic                  stall,
  output logic                  exe_hold,
  output logic                  wb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mc_busy,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int MCW = $clog2(MC_LAT);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [MCW-1:0]        r_mc_cnt;
  logic [MCW-1:0]        w_mc_cnt_nxt;
  logic                  w_issue;
  logic                  w_busy;

  logic                  r_exe_valid;
  logic [REG_ADDR_W-1:0] r_exe_rd;
  logic                  r_exe_wen;
  logic                  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_wen;

  logic [1:0]            r_fwd_a;
  logic [1:0]            r_fwd_b;
  logic [1:0]            w_sel_a;
  logic [1:0]            w_sel_b;
  logic                  w_exe_prod;
  logic                  w_wb_prod;
  logic [CNT_W-1:0]      r_stall_cycles;

  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    w_issue      = 1'b0;
    w_busy       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_issue = 1'b1;
        if (id_valid && id_multi) begin
          w_state_nxt  = MC_BUSY;
          w_mc_cnt_nxt = MCW'(MC_LAT - 1);
        end
      end
      MC_BUSY: begin
        w_busy       = 1'b1;
        w_mc_cnt_nxt = r_mc_cnt - 1'b1;
        if (r_mc_cnt == MCW'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  // nearest producer (EXE) beats the retiring one (WB); x0 never forwards
  assign w_exe_prod = r_exe_valid && r_exe_wen && (r_exe_rd != '0);
  assign w_wb_prod  = r_wb_valid && r_wb_wen && (r_wb_rd != '0);

  always_comb begin
    w_sel_a = 2'b00;
    w_sel_b = 2'b00;
    if (w_exe_prod && (r_exe_rd == id_rs1)) begin
      w_sel_a = 2'b01;
    end else if (w_wb_prod && (r_wb_rd == id_rs1)) begin
      w_sel_a = 2'b10;
    end
    if (w_exe_prod && (r_exe_rd == id_rs2)) begin
      w_sel_b = 2'b01;
    end else if (w_wb_prod && (r_wb_rd == id_rs2)) begin
      w_sel_b = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exe_valid <= 1'b0;
      r_exe_rd    <= '0;
      r_exe_wen   <= 1'b0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
    end else if (w_issue) begin
      r_exe_valid <= id_valid;
      r_exe_rd    <= id_rd;
      r_exe_wen   <= id_wen;
      r_fwd_a     <= id_valid ? w_sel_a : 2'b00;
      r_fwd_b     <= id_valid ? w_sel_b : 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_wen   <= 1'b0;
    end else if (!w_busy) begin
      r_wb_valid <= r_exe_valid;
      r_wb_rd    <= r_exe_rd;
      r_wb_wen   <= r_exe_wen;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_busy && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall        = w_busy;
  assign exe_hold     = w_busy;
  assign wb_bubble    = w_busy;
  assign mc_busy      = w_busy;
  assign fwd_a        = r_fwd_a;
  assign fwd_b        = r_fwd_b;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe4_hazard_ctrl.sv
// Directed-vector bench for pipe4_hazard_ctrl.
// A second instance (MC_LAT=6, CNT_W=2) exercises counter saturation.
module tb_pipe4_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_wen;
  logic        id_multi;

  logic        stall;
  logic        exe_hold;
  logic        wb_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mc_busy;
  logic [15:0] stall_cycles;

  logic        s_stall;
  logic        s_exe_hold;
  logic        s_wb_bubble;
  logic [1:0]  s_fwd_a;
  logic [1:0]  s_fwd_b;
  logic        s_mc_busy;
  logic [1:0]  s_stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipe4_hazard_ctrl #(.REG_ADDR_W(5), .MC_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_wen(id_wen), .id_multi(id_multi),
    .stall(stall), .exe_hold(exe_hold), .wb_bubble(wb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_busy(mc_busy),
    .stall_cycles(stall_cycles)
  );

  pipe4_hazard_ctrl #(.REG_ADDR_W(5), .MC_LAT(6), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_wen(id_wen), .id_multi(id_multi),
    .stall(s_stall), .exe_hold(s_exe_hold), .wb_bubble(s_wb_bubble),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mc_busy(s_mc_busy),
    .stall_cycles(s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic wen, input logic multi);
    id_valid = v;
    id_rs1   = rs1;
    id_rs2   = rs2;
    id_rd    = rd;
    id_wen   = wen;
    id_multi = multi;
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({stall, exe_hold, wb_bubble, mc_busy, fwd_a, fwd_b} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outs got %b exp 0",
               {stall, exe_hold, wb_bubble, mc_busy, fwd_a, fwd_b});
    end
    set_id(1, 0, 0, 1, 1, 0);
    tick();
    set_id(1, 1, 0, 2, 1, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (stall !== 1'b1 || fwd_a !== 2'b01 || stall_cycles !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_pre got stall=%b fwd_a=%b cnt=%0d exp 1 01 1",
               stall, fwd_a, stall_cycles);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || mc_busy !== 1'b0 || fwd_a !== 2'b00 ||
        fwd_b !== 2'b00 || stall_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_async got stall=%b busy=%b fa=%b fb=%b cnt=%0d exp 0",
               stall, mc_busy, fwd_a, fwd_b, stall_cycles);
    end
    rst = 1'b0;
  endtask

  task automatic test_fwd_exe();
    do_reset();
    set_id(1, 0, 0, 3, 1, 0);
    tick();
    set_id(1, 3, 9, 8, 1, 0);
    tick();
    n_checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_exe got a=%b b=%b exp a=01 b=00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_fwd_wb();
    do_reset();
    set_id(1, 0, 0, 5, 1, 0);
    tick();
    set_id(1, 0, 0, 6, 1, 0);
    tick();
    set_id(1, 6, 5, 10, 1, 0);
    tick();
    n_checks++;
    if (fwd_b !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_wb_b got %b exp 10", fwd_b);
    end
    n_checks++;
    if (fwd_a !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_wb_a got %b exp 01", fwd_a);
    end
  endtask

  task automatic test_no_fwd();
    do_reset();
    set_id(1, 0, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_x0 got a=%b b=%b exp 00", fwd_a, fwd_b);
    end
    set_id(1, 0, 0, 7, 0, 0);
    tick();
    set_id(1, 7, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (fwd_a !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_nowen got %b exp 00", fwd_a);
    end
    set_id(1, 0, 0, 3, 1, 0);
    tick();
    set_id(0, 3, 3, 0, 0, 1);
    tick();
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || mc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_issue got a=%b b=%b busy=%b exp 00 00 0",
               fwd_a, fwd_b, mc_busy);
    end
  endtask

  task automatic test_multi();
    int n_st;
    int n_bb;
    do_reset();
    set_id(1, 0, 0, 2, 1, 1);
    tick();
    set_id(1, 2, 0, 9, 1, 0);
    n_checks++;
    if ({stall, exe_hold, wb_bubble, mc_busy} !== 4'b1111) begin
      n_fail++;
      $display("FAIL mc_enter got %b exp 1111",
               {stall, exe_hold, wb_bubble, mc_busy});
    end
    n_st = 0;
    n_bb = 0;
    while (stall && n_st < 10) begin
      n_st++;
      if (wb_bubble) n_bb++;
      tick();
    end
    n_checks++;
    if (n_st != 3 || n_bb != 3) begin
      n_fail++;
      $display("FAIL mc_stall_len got stall=%0d bubble=%0d exp 3 3",
               n_st, n_bb);
    end
    tick();
    n_checks++;
    if (fwd_a !== 2'b01 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_issue got fwd_a=%b stall=%b exp 01 0", fwd_a, stall);
    end
    n_checks++;
    if (stall_cycles !== 16'd3) begin
      n_fail++;
      $display("FAIL mc_cnt got %0d exp 3", stall_cycles);
    end
  endtask

  task automatic test_back_to_back();
    int n_st;
    do_reset();
    set_id(1, 0, 0, 2, 1, 1);
    tick();
    set_id(1, 2, 2, 4, 1, 1);
    n_st = 0;
    while (stall && n_st < 10) begin
      n_st++;
      tick();
    end
    tick();
    n_checks++;
    if (mc_busy !== 1'b1 || fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_multi got busy=%b a=%b b=%b exp 1 01 01",
               mc_busy, fwd_a, fwd_b);
    end
  endtask

  task automatic test_nearest_sat();
    int n_st;
    do_reset();
    set_id(1, 0, 0, 4, 1, 0);
    tick();
    set_id(1, 0, 0, 4, 1, 0);
    tick();
    set_id(1, 4, 4, 0, 0, 0);
    tick();
    n_checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      n_fail++;
      $display("FAIL nearest got a=%b b=%b exp 01 01", fwd_a, fwd_b);
    end
    do_reset();
    set_id(1, 0, 0, 2, 1, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0);
    n_st = 0;
    for (int i = 0; i < 10; i++) begin
      if (s_stall) n_st++;
      tick();
    end
    n_checks++;
    if (n_st != 5) begin
      n_fail++;
      $display("FAIL lat6_stall got %0d exp 5", n_st);
    end
    n_checks++;
    if (s_stall_cycles !== 2'd3) begin
      n_fail++;
      $display("FAIL cnt_sat got %0d exp 3", s_stall_cycles);
    end
    n_checks++;
    if (stall_cycles !== 16'd3) begin
      n_fail++;
      $display("FAIL cnt_main got %0d exp 3", stall_cycles);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_fwd_exe();
    test_fwd_wb();
    test_no_fwd();
    test_multi();
    test_back_to_back();
    test_nearest_sat();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
